// File: rtl/matrix_scan_driver.sv
// Row-scan driver for an LED dot matrix with a double-buffered frame store.
// Rows are scanned one at a time; buffers swap only on frame boundaries.
module matrix_scan_driver #(
  parameter int ROWS      = 7,
  parameter int COLS      = 5,
  parameter int DWELL     = 4,
  parameter int BLANK_CYC = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    v,
  input  logic                    wr_en,
  input  logic [$clog2(ROWS)-1:0] wr_row,
  input  logic [COLS-1:0]         wr_data,
  input  logic                    swap_req,
  output logic [ROWS-1:0]         row_n,
  output logic [COLS-1:0]         col,
  output logic                    swap_ack,
  output logic                    frame_done,
  output logic                    busy
);

  localparam int IW   = $clog2(ROWS);
  localparam int MAXC = (DWELL > BLANK_CYC) ? DWELL : ((BLANK_CYC > 1) ? BLANK_CYC : 1);
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
  localparam logic [IW-1:0] LAST_ROW   = IW'(ROWS - 1);
  localparam logic [IW:0]   ROW_LIMIT  = (IW + 1)'(ROWS);

  typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

  state_t          state;
  logic [IW-1:0]   idx;
  logic [CW-1:0]   cnt;
  logic            front_sel;
  logic            pending;
  logic [COLS-1:0] mem [2][ROWS];

  logic            row_end;
  logic            frame_end;
  logic            swap_now;
  logic            front_next;
  logic            wr_ok;
  logic [IW-1:0]   idx_inc;
  logic [IW-1:0]   drive_idx;
  logic [ROWS-1:0] drive_row_n;
  logic [COLS-1:0] drive_col;

  always_comb begin
    row_end     = (state == DRIVE) && (cnt == DWELL_LAST);
    frame_end   = v && row_end && (idx == LAST_ROW);
    swap_now    = pending && ((state == IDLE) || frame_end);
    front_next  = front_sel ^ swap_now;
    wr_ok       = wr_en && ({1'b0, wr_row} < ROW_LIMIT);
    idx_inc     = (idx == LAST_ROW) ? '0 : idx + 1'b1;
    drive_idx   = '0;
    case (state)
      BLANK:   drive_idx = idx;
      DRIVE:   drive_idx = idx_inc;
      default: drive_idx = '0;
    endcase
    drive_row_n = ~(ROWS'(1) << drive_idx);
    drive_col   = mem[front_next][drive_idx];
    // A write on the swap edge targets the buffer about to become front; forward it.
    if (wr_ok && swap_now && (wr_row == drive_idx))
      drive_col = wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < ROWS; r++) begin
        mem[0][r] <= '0;
        mem[1][r] <= '0;
      end
    end else if (wr_ok) begin
      mem[~front_sel][wr_row] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      cnt        <= '0;
      front_sel  <= 1'b0;
      pending    <= 1'b0;
      row_n      <= '1;
      col        <= '0;
      swap_ack   <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      swap_ack   <= swap_now;
      front_sel  <= front_next;
      // A request landing on the swap edge itself is absorbed into that swap.
      pending    <= swap_now ? 1'b0 : (pending | swap_req);
      if (!v) begin
        state <= IDLE;
        idx   <= '0;
        cnt   <= '0;
        row_n <= '1;
        col   <= '0;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            idx  <= '0;
            cnt  <= '0;
            busy <= 1'b1;
            if (BLANK_CYC > 0) begin
              state <= BLANK;
              row_n <= '1;
              col   <= '0;
            end else begin
              state <= DRIVE;
              row_n <= drive_row_n;
              col   <= drive_col;
            end
          end
          BLANK: begin
            if (cnt == BLANK_LAST) begin
              state <= DRIVE;
              cnt   <= '0;
              row_n <= drive_row_n;
              col   <= drive_col;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          DRIVE: begin
            if (row_end) begin
              idx        <= idx_inc;
              cnt        <= '0;
              frame_done <= (idx == LAST_ROW);
              if (BLANK_CYC > 0) begin
                state <= BLANK;
                row_n <= '1;
                col   <= '0;
              end else begin
                state <= DRIVE;
                row_n <= drive_row_n;
                col   <= drive_col;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            row_n <= '1;
            col   <= '0;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
